// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous program-memory read and a 2-entry
// output buffer toward decode, with branch redirect and a handshake counter.
module instr_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [CNT_W-1:0]  fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [1:0]        count;
  logic [DATA_W-1:0] tail_data;
  logic [ADDR_W-1:0] tail_pc;

  logic              pop;
  logic              issue;
  logic [1:0]        keep;
  logic [2:0]        level;
  logic [1:0]        count_n;
  logic [DATA_W-1:0] head_data_n;
  logic [ADDR_W-1:0] head_pc_n;
  logic [DATA_W-1:0] tail_data_n;
  logic [ADDR_W-1:0] tail_pc_n;

  assign mem_addr = pc;

  // Issue only when every outstanding read is guaranteed a buffer slot.
  always_comb begin
    pop   = instr_valid & instr_ready;
    keep  = count - {1'b0, pop};
    level = {1'b0, keep} + {2'b00, inflight};
    issue = fetch_en & ~redirect_valid & (level < 3'd2);
  end

  // Buffer next state: head is the output register, tail shifts up on pop.
  always_comb begin
    head_data_n = instr_data;
    head_pc_n   = instr_pc;
    tail_data_n = tail_data;
    tail_pc_n   = tail_pc;
    count_n     = keep + {1'b0, inflight};
    if (pop && (count == 2'd2)) begin
      head_data_n = tail_data;
      head_pc_n   = tail_pc;
    end else begin
      head_data_n = instr_data;
      head_pc_n   = instr_pc;
    end
    if (inflight) begin
      if (keep == 2'd0) begin
        head_data_n = mem_dout;
        head_pc_n   = inflight_pc;
      end else begin
        tail_data_n = mem_dout;
        tail_pc_n   = inflight_pc;
      end
    end else begin
      tail_data_n = tail_data;
      tail_pc_n   = tail_pc;
    end
  end

  // State update; redirect discards the in-flight read and buffered words.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      tail_data   <= '0;
      tail_pc     <= '0;
      fetch_count <= '0;
    end else begin
      fetch_count <= fetch_count + CNT_W'(pop);
      if (redirect_valid) begin
        pc          <= redirect_addr;
        inflight    <= 1'b0;
        count       <= 2'd0;
        instr_valid <= 1'b0;
      end else begin
        if (issue) begin
          pc          <= pc + ADDR_W'(1);
          inflight_pc <= pc;
        end else begin
          pc          <= pc;
          inflight_pc <= inflight_pc;
        end
        inflight    <= issue;
        count       <= count_n;
        instr_valid <= (count_n != 2'd0);
        instr_data  <= head_data_n;
        instr_pc    <= head_pc_n;
        tail_data   <= tail_data_n;
        tail_pc     <= tail_pc_n;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a synchronous-read
// program memory model.
module tb_instr_fetch;

  logic        sys_clk;
  logic        reset;
  logic        fetch_en;
  logic [3:0]  mem_addr;
  logic [3:0]  mem_dout;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_data;
  logic [3:0]  instr_pc;
  logic [15:0] fetch_count;

  logic [3:0]  mem [16];
  int          mem_xor;
  int          checks;
  int          errors;
  int          exp_pc;
  int          exp_cnt;

  instr_fetch #(.ADDR_W(4), .DATA_W(4), .CNT_W(16)) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fetch_count    (fetch_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) mem_dout <= mem[mem_addr];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input int x);
    mem_xor = x;
    for (int k = 0; k < 16; k++) mem[k] = 4'(k ^ x);
  endtask

  // Expect n consecutive delivered words with ready and fetch_en held high.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      chk("st_valid", int'(instr_valid), 1);
      chk("st_pc", int'(instr_pc), exp_pc);
      chk("st_data", int'(instr_data), exp_pc ^ mem_xor);
      chk("st_count", int'(fetch_count), exp_cnt);
      tick();
      exp_pc  = (exp_pc + 1) % 16;
      exp_cnt = exp_cnt + 1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    fetch_en = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 4'h0;
    load_mem(0);
    repeat (3) tick();

    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(instr_data), 0);
    chk("rst_pc", int'(instr_pc), 0);
    chk("rst_count", int'(fetch_count), 0);

    // Cycle 0 after release
    reset = 1'b0;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    chk("c0_valid", int'(instr_valid), 0);
    chk("c0_addr", int'(mem_addr), 0);
    tick();
    chk("c1_valid", int'(instr_valid), 0);
    chk("c1_addr", int'(mem_addr), 1);
    tick();
    exp_pc = 0;
    exp_cnt = 0;
    stream(18);
    chk("wrap_count", int'(fetch_count), 18);

    // Back-pressure for 5 cycles: head held, address frozen
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(instr_valid), 1);
      chk("bp_pc", int'(instr_pc), 2);
      chk("bp_data", int'(instr_data), 2);
      chk("bp_addr", int'(mem_addr), 4);
      chk("bp_count", int'(fetch_count), 18);
      tick();
    end
    instr_ready = 1'b1;
    stream(6);

    // Fill the buffer, then redirect to 0xA with ready low
    instr_ready = 1'b0;
    chk("fill_pc", int'(instr_pc), 8);
    tick();
    chk("full_addr", int'(mem_addr), 10);
    chk("full_pc", int'(instr_pc), 8);
    redirect_valid = 1'b1;
    redirect_addr = 4'hA;
    load_mem(5);
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    chk("rda_valid1", int'(instr_valid), 0);
    chk("rda_addr", int'(mem_addr), 10);
    chk("rda_count", int'(fetch_count), 24);
    tick();
    chk("rda_valid2", int'(instr_valid), 0);
    tick();
    exp_pc = 10;
    stream(4);

    // Redirect coinciding with a pop of word 0xE
    chk("rdb_head", int'(instr_pc), 14);
    redirect_valid = 1'b1;
    redirect_addr = 4'h3;
    tick();
    exp_cnt = exp_cnt + 1;
    redirect_valid = 1'b0;
    chk("rdb_valid1", int'(instr_valid), 0);
    chk("rdb_addr", int'(mem_addr), 3);
    chk("rdb_count", int'(fetch_count), exp_cnt);
    tick();
    chk("rdb_valid2", int'(instr_valid), 0);
    tick();
    exp_pc = 3;
    stream(4);

    // fetch_en toggling, then held low to drain
    for (int i = 0; i < 12; i++) begin
      int ev;
      fetch_en = (i < 8) ? 1'(i % 2) : 1'b0;
      ev = ((i < 2) || ((i % 2 == 1) && (i < 10))) ? 1 : 0;
      chk("tg_valid", int'(instr_valid), ev);
      if (ev == 1) begin
        chk("tg_pc", int'(instr_pc), exp_pc);
        chk("tg_data", int'(instr_data), exp_pc ^ mem_xor);
        exp_pc = (exp_pc + 1) % 16;
        exp_cnt = exp_cnt + 1;
      end
      tick();
    end
    chk("drain_valid", int'(instr_valid), 0);
    chk("drain_addr", int'(mem_addr), exp_pc);
    chk("drain_count", int'(fetch_count), exp_cnt);

    // Restart, then reset while a word is valid and a read is in flight
    fetch_en = 1'b1;
    tick();
    tick();
    chk("pre_rst_valid", int'(instr_valid), 1);
    chk("pre_rst_pc", int'(instr_pc), 13);
    reset = 1'b1;
    tick();
    chk("mrst_valid", int'(instr_valid), 0);
    chk("mrst_addr", int'(mem_addr), 0);
    chk("mrst_data", int'(instr_data), 0);
    chk("mrst_pc", int'(instr_pc), 0);
    chk("mrst_count", int'(fetch_count), 0);
    reset = 1'b0;
    tick();
    chk("mrst_c1_valid", int'(instr_valid), 0);
    tick();
    exp_pc = 0;
    exp_cnt = 0;
    stream(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
